fifo_push_ctrl: RTL and testbench

//  Write-side initiator for the async 2-entry FIFO push/full interface, in the wclk domain.

---
 rtl/fifo_push_ctrl_pkg.sv | 14 +
 rtl/fifo_push_ctrl_if.sv | 23 ++
 rtl/fifo_push_ctrl_skid_buf2.sv | 53 +++++
 rtl/fifo_push_ctrl.sv | 77 +++++++
 tb/tb_fifo_push_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_push_ctrl_pkg.sv
// Shared types and constants for the FIFO write-side push controller.
package fifo_push_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int BUF_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    BLOCKED = 2'd2
  } push_state_e;

endpackage

// File: rtl/fifo_push_ctrl_if.sv
// Upstream valid/ready stream plus FIFO push/full bus seen by the push controller.
interface fifo_push_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              flush;
  logic              full;
  logic              push;
  logic [DATA_W-1:0] wdata;

  // master: upstream producer plus FIFO write side; slave: the push controller
  modport master (
    output in_valid, in_data, flush, full,
    input  in_ready, push, wdata
  );

  modport slave (
    input  in_valid, in_data, flush, full,
    output in_ready, push, wdata
  );
endinterface

// File: rtl/fifo_push_ctrl_skid_buf2.sv
// Two-entry in-order skid buffer: entry 0 is always the head, entry 1 the tail.
module fifo_push_ctrl_skid_buf2
  import fifo_push_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_wclk,
  input  logic              i_reset_w_n,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count,
  output logic [1:0]        o_count_nxt
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  logic [DATA_W-1:0] r_e0;
  logic [DATA_W-1:0] r_e1;
  logic [1:0]        r_count;
  logic              w_accept;
  logic              w_slot0;

  assign o_ready     = (r_count != FULL_CNT) & ~i_flush;
  assign w_accept    = i_valid & o_ready;
  assign o_count_nxt = i_flush ? 2'd0 : (r_count + 2'(w_accept) - 2'(i_pop));
  assign o_head      = r_e0;
  assign o_count     = r_count;

  // A new word lands at the head when the buffer is (or becomes, via pop) empty.
  assign w_slot0 = (r_count == 2'd0) | ((r_count == 2'd1) & i_pop);

  always_ff @(posedge i_wclk or negedge i_reset_w_n) begin
    if (!i_reset_w_n) begin
      r_count <= 2'd0;
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      r_count <= o_count_nxt;
      if (!i_flush) begin
        if (i_pop) r_e0 <= r_e1;
        if (w_accept) begin
          if (w_slot0) r_e0 <= i_data;
          else         r_e1 <= i_data;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_push_ctrl.sv
// FIFO write-side push controller: buffers upstream words and pushes them only
// when full is low now and was low on the previous wclk edge.
module fifo_push_ctrl
  import fifo_push_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             i_wclk,
  input  logic             i_reset_w_n,
  fifo_push_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] o_push_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic [1:0]        w_count;
  logic [1:0]        w_count_nxt;
  logic [DATA_W-1:0] w_head;
  logic              w_in_ready;
  logic              w_push;
  logic              w_blocked;
  logic              r_full_q;
  push_state_e       r_state;
  push_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_push_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  fifo_push_ctrl_skid_buf2 #(.DATA_W(DATA_W)) u_buf (
    .i_wclk      (i_wclk),
    .i_reset_w_n (i_reset_w_n),
    .i_flush     (bus.flush),
    .i_valid     (bus.in_valid),
    .i_data      (bus.in_data),
    .o_ready     (w_in_ready),
    .i_pop       (w_push),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_count_nxt (w_count_nxt)
  );

  // full_q resets high so nothing is pushed before full has been sampled low once.
  assign w_push    = (w_count != 2'd0) & ~bus.full & ~r_full_q & ~bus.flush;
  assign w_blocked = (r_state != IDLE) & ~w_push & ~bus.flush;

  assign bus.in_ready = w_in_ready;
  assign bus.push     = w_push;
  assign bus.wdata    = w_head;
  assign o_push_cnt   = r_push_cnt;
  assign o_stall_cnt  = r_stall_cnt;

  // The registered state anticipates the next cycle: next count and next full_q (= full now).
  always_comb begin
    w_state_nxt = IDLE;
    if (!bus.flush && (w_count_nxt != 2'd0)) begin
      w_state_nxt = bus.full ? BLOCKED : SEND;
    end
  end

  always_ff @(posedge i_wclk or negedge i_reset_w_n) begin
    if (!i_reset_w_n) begin
      r_full_q    <= 1'b1;
      r_state     <= IDLE;
      r_push_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_full_q <= bus.full;
      r_state  <= w_state_nxt;
      if (w_push)    r_push_cnt  <= r_push_cnt + CNT_W'(1);
      if (w_blocked) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

endmodule

// File: tb/tb_fifo_push_ctrl.sv
// Directed and random bench for fifo_push_ctrl with a push-side scoreboard.
module tb_fifo_push_ctrl;
  import fifo_push_ctrl_pkg::*;

  logic        wclk;
  logic        reset_w_n;
  logic [15:0] push_cnt;
  logic [15:0] stall_cnt;

  fifo_push_ctrl_if #(.DATA_W(8)) bus ();

  fifo_push_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
    .i_wclk      (wclk),
    .i_reset_w_n (reset_w_n),
    .bus         (bus),
    .o_push_cnt  (push_cnt),
    .o_stall_cnt (stall_cnt)
  );

  int vectors    = 0;
  int miscompares = 0;
  int n_acc      = 0;
  int n_drop     = 0;

  logic [7:0] exp_q[$];
  logic       s_push;
  logic [7:0] s_wdata;
  logic       s_in_ready;
  logic       full_prev;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock of stimulus; samples outputs at the falling edge and books accepted/flushed words.
  task automatic cycle(input logic v, input logic [7:0] d, input logic fl, input logic fu);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.flush    = fl;
    bus.full     = fu;
    @(negedge wclk);
    s_push     = bus.push;
    s_wdata    = bus.wdata;
    s_in_ready = bus.in_ready;
    if (fl) begin
      n_drop += exp_q.size();
      exp_q.delete();
    end
    if (v && bus.in_ready) begin
      exp_q.push_back(d);
      n_acc++;
    end
    @(posedge wclk);
    #1;
  endtask

  // Monitor: every push must carry the oldest outstanding word and respect full/full history.
  initial begin
    logic [7:0] e;
    full_prev = 1'b1;
    forever begin
      @(negedge wclk);
      if (reset_w_n && bus.push) begin
        check("push_protocol", {31'b0, (!bus.full && !full_prev)}, 32'd1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL push_unexpected: got wdata %0h, expected no push", bus.wdata);
        end else begin
          e = exp_q.pop_front();
          check("wdata_order", {24'b0, bus.wdata}, {24'b0, e});
        end
      end
      full_prev = bus.full;
    end
  end

  ap_push_full: assert property (@(posedge wclk) disable iff (!reset_w_n)
                                 bus.push |-> (!bus.full && !$past(bus.full)))
    else begin
      miscompares++;
      $display("FAIL push_assert: push high with full=%0b", bus.full);
    end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_w_n    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.flush    = 1'b0;
    bus.full     = 1'b0;

    // reset state
    repeat (2) @(negedge wclk);
    check("rst_push",     {31'b0, bus.push}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_wdata",    {24'b0, bus.wdata}, 32'd0);
    check("rst_push_cnt", {16'b0, push_cnt}, 32'd0);
    check("rst_stall",    {16'b0, stall_cnt}, 32'd0);
    check("rst_count",    {30'b0, dut.u_buf.r_count}, 32'd0);
    check("rst_state",    32'(dut.r_state), 32'(IDLE));
    @(posedge wclk);
    #1;
    reset_w_n = 1'b1;

    // single word: push one cycle after accept
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("t1_accept_push", {31'b0, s_push}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t1_push",  {31'b0, s_push}, 32'd1);
    check("t1_wdata", {24'b0, s_wdata}, 32'hA5);
    check("t1_push_cnt", {16'b0, push_cnt}, 32'd1);

    // back-to-back words at full throughput
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    check("t2_rdy0", {31'b0, s_in_ready}, 32'd1);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    check("t2_rdy1", {31'b0, s_in_ready}, 32'd1);
    check("t2_push1", {31'b0, s_push}, 32'd1);
    check("t2_wd1", {24'b0, s_wdata}, 32'h01);
    cycle(1'b1, 8'h03, 1'b0, 1'b0);
    check("t2_rdy2", {31'b0, s_in_ready}, 32'd1);
    check("t2_push2", {31'b0, s_push}, 32'd1);
    check("t2_wd2", {24'b0, s_wdata}, 32'h02);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t2_push3", {31'b0, s_push}, 32'd1);
    check("t2_wd3", {24'b0, s_wdata}, 32'h03);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t2_idle", {31'b0, s_push}, 32'd0);
    check("t2_push_cnt", {16'b0, push_cnt}, 32'd4);

    // full held 5 cycles with two words buffered, then one bubble after full falls
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    cycle(1'b1, 8'h12, 1'b0, 1'b1);
    check("t3_rdy_cnt1", {31'b0, s_in_ready}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("t3_count", {30'b0, dut.u_buf.r_count}, 32'd2);
    check("t3_state", 32'(dut.r_state), 32'(BLOCKED));
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("t3_rdy_full", {31'b0, s_in_ready}, 32'd0);
    check("t3_push_full", {31'b0, s_push}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t3_bubble", {31'b0, s_push}, 32'd0);
    check("t3_stall", {16'b0, stall_cnt}, 32'd5);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t3_push_a", {31'b0, s_push}, 32'd1);
    check("t3_wd_a", {24'b0, s_wdata}, 32'h11);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t3_push_b", {31'b0, s_push}, 32'd1);
    check("t3_wd_b", {24'b0, s_wdata}, 32'h12);
    check("t3_push_cnt", {16'b0, push_cnt}, 32'd6);
    check("t3_stall_hold", {16'b0, stall_cnt}, 32'd5);

    // flush with the buffer full and FIFO full
    cycle(1'b1, 8'h21, 1'b0, 1'b1);
    cycle(1'b1, 8'h22, 1'b0, 1'b1);
    cycle(1'b1, 8'h23, 1'b1, 1'b1);
    check("t4_flush_rdy", {31'b0, s_in_ready}, 32'd0);
    check("t4_flush_push", {31'b0, s_push}, 32'd0);
    check("t4_count", {30'b0, dut.u_buf.r_count}, 32'd0);
    check("t4_state", 32'(dut.r_state), 32'(IDLE));
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_rdy", {31'b0, s_in_ready}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t4_no_push", {31'b0, s_push}, 32'd0);
    check("t4_push_cnt", {16'b0, push_cnt}, 32'd6);
    check("t4_stall", {16'b0, stall_cnt}, 32'd6);

    // asynchronous reset in the middle of a burst
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    #2;
    check("t5_pre_push", {31'b0, bus.push}, 32'd1);
    check("t5_pre_wdata", {24'b0, bus.wdata}, 32'h32);
    reset_w_n = 1'b0;
    #1;
    check("t5_push", {31'b0, bus.push}, 32'd0);
    check("t5_rdy", {31'b0, bus.in_ready}, 32'd1);
    check("t5_wdata", {24'b0, bus.wdata}, 32'd0);
    check("t5_push_cnt", {16'b0, push_cnt}, 32'd0);
    check("t5_stall", {16'b0, stall_cnt}, 32'd0);
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(posedge wclk);
    #1;
    reset_w_n = 1'b1;
    cycle(1'b1, 8'h41, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_bubble", {31'b0, s_push}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_first_push", {31'b0, s_push}, 32'd1);
    check("t5_first_wd", {24'b0, s_wdata}, 32'h41);
    check("t5_push_cnt2", {16'b0, push_cnt}, 32'd1);

    // random full/valid/flush traffic
    n_acc  = 0;
    n_drop = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 4));
    end
    repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t6_drained", exp_q.size(), 32'd0);
    check("t6_push_cnt", {16'b0, push_cnt}, 32'(1 + n_acc - n_drop));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
